// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, taken-branch
// flushes, data-memory wait freezes and a sticky memory-timeout error state.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W  = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [REG_ADDR_W-1:0]  id_rn,
  input  logic [REG_ADDR_W-1:0]  id_rm,
  input  logic                   id_rn_used,
  input  logic                   id_rm_used,
  input  logic [REG_ADDR_W-1:0]  ex_rd,
  input  logic                   ex_mem_read,
  input  logic                   ex_reg_write,
  input  logic                   ex_branch_taken,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  output logic                   pc_en,
  output logic                   if_id_en,
  output logic                   id_ex_en,
  output logic                   ex_mem_en,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic                   mem_wb_bubble,
  output logic                   timeout_err,
  output logic [STALL_CNT_W-1:0] stall_count,
  output logic [1:0]             fsm_state
);

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [WAIT_W-1:0] wait_cnt, wait_next;
  logic              freeze;
  logic              rn_hit, rm_hit;
  logic              load_use;

  // Memory handshake: mem_req marks an access in MEM; the access completes in
  // the cycle mem_ready is high. Any cycle with mem_req & !mem_ready freezes.
  assign freeze   = mem_req & ~mem_ready;
  assign rn_hit   = id_rn_used & (id_rn == ex_rd);
  assign rm_hit   = id_rm_used & (id_rm == ex_rd);
  assign load_use = ex_mem_read & ex_reg_write & (rn_hit | rm_hit);

  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
    end
  end

  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    case (state)
      ST_RUN: begin
        if (freeze) begin
          state_next = ST_WAIT;
          wait_next  = WAIT_W'(1);
        end
      end
      ST_WAIT: begin
        if (!mem_req || mem_ready) begin
          state_next = ST_RUN;
          wait_next  = '0;
        end else if (wait_cnt == WAIT_MAX) begin
          state_next = ST_ERROR;
        end else begin
          wait_next = wait_cnt + WAIT_W'(1);
        end
      end
      ST_ERROR: state_next = ST_ERROR;
      default: begin
        state_next = ST_RUN;
        wait_next  = '0;
      end
    endcase
  end

  // Priority: reset, error, freeze, branch, load-use, then defaults.
  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    if (reset) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (state == ST_ERROR || freeze) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_err <= 1'b0;
    end else if (state_next == ST_ERROR) begin
      timeout_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (!pc_en && (stall_count != {STALL_CNT_W{1'b1}})) begin
      stall_count <= stall_count + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed vector table, multi-cycle corner
// sequences, and random traffic against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int TMO   = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  typedef struct packed {
    logic       rst;
    logic [3:0] rn;
    logic [3:0] rm;
    logic       rnu;
    logic       rmu;
    logic [3:0] rd;
    logic       mr;
    logic       rw;
    logic       br;
    logic       req;
    logic       rdy;
  } stim_t;

  typedef struct packed {
    logic [3:0] en;   // pc, if_id, id_ex, ex_mem
    logic [2:0] fl;   // if_id_flush, id_ex_flush, mem_wb_bubble
    logic       err;
    logic [3:0] cnt;
    logic [1:0] st;
  } resp_t;

  typedef struct {
    stim_t s;
    resp_t r;
  } vec_t;

  localparam logic [3:0] EN_ALL = 4'b1111;
  localparam logic [3:0] EN_LU  = 4'b0011;
  localparam logic [3:0] EN_NO  = 4'b0000;
  localparam logic [2:0] FL_NO  = 3'b000;
  localparam logic [2:0] FL_RST = 3'b111;
  localparam logic [2:0] FL_BR  = 3'b110;
  localparam logic [2:0] FL_LU  = 3'b010;
  localparam logic [2:0] FL_FRZ = 3'b001;
  localparam logic [1:0] RUN = 2'd0, WAITS = 2'd1, ERR = 2'd2;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] id_rn, id_rm, ex_rd;
  logic id_rn_used, id_rm_used, ex_mem_read, ex_reg_write, ex_branch_taken;
  logic mem_req, mem_ready;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic if_id_flush, id_ex_flush, mem_wb_bubble, timeout_err;
  logic [CW-1:0] stall_count;
  logic [1:0] fsm_state;

  int checks = 0;
  int passes = 0;

  // Reference model state: error latched, run length of consecutive freeze
  // cycles, and the ideal (saturated) stall-cycle count.
  bit m_err;
  int m_fz;
  int m_cnt;

  vec_t tbl[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .REG_ADDR_W (4),
    .MEM_TIMEOUT(TMO),
    .STALL_CNT_W(CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .id_rn          (id_rn),
    .id_rm          (id_rm),
    .id_rn_used     (id_rn_used),
    .id_rm_used     (id_rm_used),
    .ex_rd          (ex_rd),
    .ex_mem_read    (ex_mem_read),
    .ex_reg_write   (ex_reg_write),
    .ex_branch_taken(ex_branch_taken),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .pc_en          (pc_en),
    .if_id_en       (if_id_en),
    .id_ex_en       (id_ex_en),
    .ex_mem_en      (ex_mem_en),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .mem_wb_bubble  (mem_wb_bubble),
    .timeout_err    (timeout_err),
    .stall_count    (stall_count),
    .fsm_state      (fsm_state)
  );

  function automatic stim_t mk(logic rst, logic [3:0] rn, logic [3:0] rm,
                               logic rnu, logic rmu, logic [3:0] rd, logic mr,
                               logic rw, logic br, logic req, logic rdy);
    stim_t s;
    s = {rst, rn, rm, rnu, rmu, rd, mr, rw, br, req, rdy};
    return s;
  endfunction

  function automatic resp_t rs(logic [3:0] en, logic [2:0] fl, logic err,
                               int cnt, logic [1:0] st);
    resp_t r;
    r = {en, fl, err, 4'(cnt), st};
    return r;
  endfunction

  task automatic add(input stim_t s, input resp_t r);
    vec_t v;
    v.s = s;
    v.r = r;
    tbl.push_back(v);
  endtask

  task automatic drive(input stim_t s);
    reset           = s.rst;
    id_rn           = s.rn;
    id_rm           = s.rm;
    id_rn_used      = s.rnu;
    id_rm_used      = s.rmu;
    ex_rd           = s.rd;
    ex_mem_read     = s.mr;
    ex_reg_write    = s.rw;
    ex_branch_taken = s.br;
    mem_req         = s.req;
    mem_ready       = s.rdy;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic cycle(input stim_t s, input resp_t e, input string name);
    resp_t a;
    @(negedge clk);
    drive(s);
    #1;
    a = {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
         mem_wb_bubble, timeout_err, stall_count, fsm_state};
    checks++;
    if (a === e) passes++;
    else $display("FAIL %s: got en=%b fl=%b err=%b cnt=%0d st=%0d, want en=%b fl=%b err=%b cnt=%0d st=%0d",
                  name, a.en, a.fl, a.err, a.cnt, a.st, e.en, e.fl, e.err, e.cnt, e.st);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  function automatic resp_t model_out(stim_t s);
    resp_t r;
    bit lu;
    r.err = m_err;
    r.cnt = 4'(m_cnt);
    r.st  = m_err ? ERR : (m_fz > 0 ? WAITS : RUN);
    lu = s.mr && s.rw && ((s.rnu && s.rn == s.rd) || (s.rmu && s.rm == s.rd));
    if (s.rst)                        begin r.en = EN_NO;  r.fl = FL_RST; end
    else if (m_err || (s.req && !s.rdy)) begin r.en = EN_NO; r.fl = FL_FRZ; end
    else if (s.br)                    begin r.en = EN_ALL; r.fl = FL_BR;  end
    else if (lu)                      begin r.en = EN_LU;  r.fl = FL_LU;  end
    else                              begin r.en = EN_ALL; r.fl = FL_NO;  end
    return r;
  endfunction

  task automatic model_adv(input stim_t s);
    resp_t r;
    r = model_out(s);
    if (s.rst) begin
      m_err = 0;
      m_fz  = 0;
      m_cnt = 0;
    end else begin
      if (!r.en[3] && m_cnt < CMAX) m_cnt++;
      if (!m_err) begin
        if (s.req && !s.rdy) begin
          m_fz++;
          if (m_fz == TMO + 1) m_err = 1;
        end else begin
          m_fz = 0;
        end
      end
    end
  endtask

  initial begin
    stim_t idle, frz, lu;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    frz  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    lu   = mk(0, 3, 0, 1, 0, 3, 1, 1, 0, 0, 0);

    // Directed table: expected stall_count is the value before each cycle.
    add(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), rs(EN_NO,  FL_RST, 0, 0, RUN));
    add(mk(0, 3, 0, 1, 0, 3, 1, 1, 0, 0, 0), rs(EN_LU,  FL_LU,  0, 0, RUN));
    add(mk(0, 5, 0, 1, 0, 3, 1, 1, 0, 0, 0), rs(EN_ALL, FL_NO,  0, 1, RUN));
    add(mk(0, 3, 0, 1, 0, 3, 1, 1, 1, 0, 0), rs(EN_ALL, FL_BR,  0, 1, RUN));
    add(mk(0, 5, 3, 1, 0, 3, 1, 1, 0, 0, 0), rs(EN_ALL, FL_NO,  0, 1, RUN));
    add(mk(0, 5, 3, 1, 1, 3, 1, 1, 0, 0, 0), rs(EN_LU,  FL_LU,  0, 1, RUN));
    add(mk(0, 3, 0, 1, 0, 3, 0, 1, 0, 0, 0), rs(EN_ALL, FL_NO,  0, 2, RUN));
    add(mk(0, 3, 0, 1, 0, 3, 1, 0, 0, 0, 0), rs(EN_ALL, FL_NO,  0, 2, RUN));
    add(mk(0, 3, 3, 0, 0, 3, 1, 1, 0, 0, 0), rs(EN_ALL, FL_NO,  0, 2, RUN));
    add(mk(1, 3, 0, 1, 0, 3, 1, 1, 0, 0, 0), rs(EN_NO,  FL_RST, 0, 2, RUN));
    add(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), rs(EN_ALL, FL_NO,  0, 0, RUN));
    add(mk(0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0), rs(EN_LU,  FL_LU,  0, 0, RUN));
    add(mk(0, 7, 15, 1, 1, 15, 1, 1, 0, 0, 0), rs(EN_LU, FL_LU, 0, 1, RUN));
    add(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), rs(EN_ALL, FL_NO,  0, 2, RUN));

    drive(idle);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < tbl.size(); i++)
      cycle(tbl[i].s, tbl[i].r, $sformatf("tbl%0d", i));

    // Three-cycle memory wait; branch and load-use masked during the freeze.
    do_reset();
    cycle(frz, rs(EN_NO, FL_FRZ, 0, 0, RUN), "wait_frz1");
    cycle(mk(0, 3, 0, 1, 0, 3, 1, 1, 1, 1, 0), rs(EN_NO, FL_FRZ, 0, 1, WAITS), "wait_frz2_masked");
    cycle(frz, rs(EN_NO, FL_FRZ, 0, 2, WAITS), "wait_frz3");
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), rs(EN_ALL, FL_NO, 0, 3, WAITS), "wait_release");
    cycle(idle, rs(EN_ALL, FL_NO, 0, 3, RUN), "wait_back_run");

    // Timeout: MEM_TIMEOUT+1 freeze cycles, then sticky error until reset.
    do_reset();
    for (int i = 1; i <= TMO + 1; i++)
      cycle(frz, rs(EN_NO, FL_FRZ, 0, i - 1, (i == 1) ? RUN : WAITS), $sformatf("tmo_frz%0d", i));
    cycle(frz, rs(EN_NO, FL_FRZ, 1, 5, ERR), "tmo_err");
    cycle(idle, rs(EN_NO, FL_FRZ, 1, 6, ERR), "tmo_sticky_noreq");
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1), rs(EN_NO, FL_FRZ, 1, 7, ERR), "tmo_sticky_ready");
    cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), rs(EN_NO, FL_RST, 1, 8, ERR), "tmo_reset");
    cycle(idle, rs(EN_ALL, FL_NO, 0, 0, RUN), "tmo_cleared");

    // Reset in mid-wait, then a fresh wait needs the full budget again.
    do_reset();
    cycle(frz, rs(EN_NO, FL_FRZ, 0, 0, RUN), "midrst_frz1");
    cycle(frz, rs(EN_NO, FL_FRZ, 0, 1, WAITS), "midrst_frz2");
    cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), rs(EN_NO, FL_RST, 0, 2, WAITS), "midrst_reset");
    for (int i = 1; i <= TMO + 1; i++)
      cycle(frz, rs(EN_NO, FL_FRZ, 0, i - 1, (i == 1) ? RUN : WAITS), $sformatf("midrst_rewait%0d", i));
    cycle(frz, rs(EN_NO, FL_FRZ, 1, 5, ERR), "midrst_err");

    // Saturation of the stall counter under back-to-back load-use stalls.
    do_reset();
    for (int k = 0; k < 20; k++)
      cycle(lu, rs(EN_LU, FL_LU, 0, (k < CMAX) ? k : CMAX, RUN), $sformatf("sat%0d", k));
    cycle(idle, rs(EN_ALL, FL_NO, 0, CMAX, RUN), "sat_hold");

    // Random traffic against the reference model.
    do_reset();
    m_err = 0;
    m_fz  = 0;
    m_cnt = 0;
    for (int n = 0; n < 1500; n++) begin
      stim_t s;
      s.rst = ($urandom_range(0, 59) == 0);
      s.rn  = 4'($urandom_range(0, 3));
      s.rm  = 4'($urandom_range(0, 3));
      s.rnu = 1'($urandom_range(0, 1));
      s.rmu = 1'($urandom_range(0, 1));
      s.rd  = 4'($urandom_range(0, 3));
      s.mr  = 1'($urandom_range(0, 1));
      s.rw  = ($urandom_range(0, 3) != 0);
      s.br  = ($urandom_range(0, 5) == 0);
      s.req = 1'($urandom_range(0, 1));
      s.rdy = ($urandom_range(0, 2) == 0);
      cycle(s, model_out(s), $sformatf("rand%0d", n));
      model_adv(s);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
